// File: rtl/config_sequencer.sv
// Configuration-bus sequencer: drives (addr, data) words onto the tile broadcast bus
// with a hold window and an idle gap. Optional tile-id filtering under CFG_TILE_CHECK_EN.
module config_sequencer #(
  parameter int HOLD_CYCLES = 2,
  parameter int GAP_CYCLES  = 1,
  parameter int NUM_TILES   = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             abort,
  input  logic             cfg_in_valid,
  output logic             cfg_in_ready,
  input  logic [31:0]      cfg_in_addr,
  input  logic [31:0]      cfg_in_data,
  input  logic             cfg_in_last,
  output logic [31:0]      config_addr,
  output logic [31:0]      config_data,
  output logic             config_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] word_count,
  output logic [CNT_W-1:0] err_count
);

`ifdef CFG_TILE_CHECK_EN
  localparam logic TILE_CHECK = 1'b1;
`else
  localparam logic TILE_CHECK = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

  state_t      state, state_nxt;
  logic [15:0] tmr;
  logic        last_q, clr_pend;
  logic        tile_bad, hs, drop, issue, hold_end, gap_end, word_end;

  assign tile_bad = (cfg_in_addr[31:16] >= 16'(NUM_TILES)) && (cfg_in_addr[31:16] != 16'hFFFF);
  assign hs       = cfg_in_valid & cfg_in_ready & ~abort;
  assign drop     = hs & tile_bad & TILE_CHECK;
  assign issue    = hs & ~drop;
  assign hold_end = (state == HOLD) && (tmr == 16'(HOLD_CYCLES - 1));
  assign gap_end  = (state == GAP) && (tmr == 16'(GAP_CYCLES - 1));
  // A word completes at the edge returning to IDLE; abort suppresses completion.
  assign word_end = ~abort & (gap_end | (hold_end & (GAP_CYCLES == 0)));

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (issue) state_nxt = HOLD;
        HOLD:    if (hold_end) state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
        GAP:     if (gap_end) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    cfg_in_ready = reset & (state == IDLE);
    config_en    = (state == HOLD);
    busy         = (state != IDLE);
  end

  // Cycle timer restarts on every state change.
  always_ff @(posedge clk) begin
    if (!reset)                  tmr <= '0;
    else if (state_nxt != state) tmr <= '0;
    else                         tmr <= tmr + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      config_addr <= '0;
      config_data <= '0;
      last_q      <= 1'b0;
      clr_pend    <= 1'b0;
      done        <= 1'b0;
      word_count  <= '0;
      err_count   <= '0;
    end else begin
      done <= 1'b0;
      if (issue) begin
        config_addr <= cfg_in_addr;
        config_data <= cfg_in_data;
        last_q      <= cfg_in_last;
        word_count  <= clr_pend ? CNT_W'(1) : word_count + CNT_W'(1);
        if (clr_pend) err_count <= '0;
        clr_pend    <= 1'b0;
      end else if (drop) begin
        err_count <= clr_pend ? CNT_W'(1) : err_count + CNT_W'(1);
        if (clr_pend) word_count <= '0;
        clr_pend  <= cfg_in_last;
        done      <= cfg_in_last;
      end else if (word_end && last_q) begin
        done     <= 1'b1;
        clr_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_config_sequencer.sv
// Directed bench for config_sequencer: default instance (HOLD=2, GAP=1) plus a GAP=0 instance.
module tb_config_sequencer;
  logic        clk = 1'b0, reset = 1'b0, abort = 1'b0;
  logic        cfg_in_valid = 1'b0, cfg_in_last = 1'b0;
  logic [31:0] cfg_in_addr = '0, cfg_in_data = '0;
  logic        cfg_in_ready, config_en, busy, done;
  logic [31:0] config_addr, config_data;
  logic [15:0] word_count, err_count;

  logic        g_abort = 1'b0, g_valid = 1'b0, g_last = 1'b0;
  logic [31:0] g_addr = '0, g_data = '0;
  logic        g_ready, g_en, g_busy, g_done;
  logic [31:0] g_caddr, g_cdata;
  logic [15:0] g_wc, g_ec;

  int nvec = 0, nerr = 0;

  config_sequencer #(.HOLD_CYCLES(2), .GAP_CYCLES(1), .NUM_TILES(16), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .abort(abort), .cfg_in_valid(cfg_in_valid),
    .cfg_in_ready(cfg_in_ready), .cfg_in_addr(cfg_in_addr), .cfg_in_data(cfg_in_data),
    .cfg_in_last(cfg_in_last), .config_addr(config_addr), .config_data(config_data),
    .config_en(config_en), .busy(busy), .done(done), .word_count(word_count),
    .err_count(err_count));

  config_sequencer #(.HOLD_CYCLES(2), .GAP_CYCLES(0), .NUM_TILES(16), .CNT_W(16)) dut_g0 (
    .clk(clk), .reset(reset), .abort(g_abort), .cfg_in_valid(g_valid),
    .cfg_in_ready(g_ready), .cfg_in_addr(g_addr), .cfg_in_data(g_data),
    .cfg_in_last(g_last), .config_addr(g_caddr), .config_data(g_cdata),
    .config_en(g_en), .busy(g_busy), .done(g_done), .word_count(g_wc),
    .err_count(g_ec));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // Present a word and return one cycle after its handshake edge.
  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic l);
    int n;
    n = 0;
    cfg_in_valid = 1'b1; cfg_in_addr = a; cfg_in_data = d; cfg_in_last = l;
    while (!cfg_in_ready && n < 20) begin tick; n++; end
    nvec++; if (cfg_in_ready !== 1'b1) begin nerr++; $display("FAIL push_ready got=%b want=1", cfg_in_ready); end
    tick;
    cfg_in_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; tick; tick;
    nvec++; if (config_en !== 1'b0) begin nerr++; $display("FAIL rst_en got=%b want=0", config_en); end
    nvec++; if (config_addr !== 32'h0) begin nerr++; $display("FAIL rst_addr got=%h want=0", config_addr); end
    nvec++; if (config_data !== 32'h0) begin nerr++; $display("FAIL rst_data got=%h want=0", config_data); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rst_busy got=%b want=0", busy); end
    nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL rst_done got=%b want=0", done); end
    nvec++; if (word_count !== 16'd0) begin nerr++; $display("FAIL rst_wc got=%0d want=0", word_count); end
    nvec++; if (err_count !== 16'd0) begin nerr++; $display("FAIL rst_ec got=%0d want=0", err_count); end
    nvec++; if (cfg_in_ready !== 1'b0) begin nerr++; $display("FAIL rst_ready_held got=%b want=0", cfg_in_ready); end
    reset = 1'b1; #1;
    nvec++; if (cfg_in_ready !== 1'b1) begin nerr++; $display("FAIL rst_ready_rel got=%b want=1", cfg_in_ready); end
  endtask

  task automatic test_single;
    push(32'h0003_0001, 32'hDEAD_BEEF, 1'b1);
    nvec++; if (config_en !== 1'b1) begin nerr++; $display("FAIL single_en1 got=%b want=1", config_en); end
    nvec++; if (config_addr !== 32'h0003_0001) begin nerr++; $display("FAIL single_addr got=%h want=00030001", config_addr); end
    nvec++; if (config_data !== 32'hDEAD_BEEF) begin nerr++; $display("FAIL single_data got=%h want=deadbeef", config_data); end
    nvec++; if (cfg_in_ready !== 1'b0) begin nerr++; $display("FAIL single_rdy1 got=%b want=0", cfg_in_ready); end
    nvec++; if (word_count !== 16'd1) begin nerr++; $display("FAIL single_wc got=%0d want=1", word_count); end
    tick;
    nvec++; if (config_en !== 1'b1) begin nerr++; $display("FAIL single_en2 got=%b want=1", config_en); end
    tick;
    nvec++; if (config_en !== 1'b0) begin nerr++; $display("FAIL single_en3 got=%b want=0", config_en); end
    nvec++; if ({busy, cfg_in_ready} !== 2'b10) begin nerr++; $display("FAIL single_gap got=%b want=10", {busy, cfg_in_ready}); end
    nvec++; if (config_addr !== 32'h0003_0001) begin nerr++; $display("FAIL single_addr_gap got=%h want=00030001", config_addr); end
    nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL single_early_done got=%b want=0", done); end
    tick;
    nvec++; if ({done, cfg_in_ready, busy} !== 3'b110) begin nerr++; $display("FAIL single_done got=%b want=110", {done, cfg_in_ready, busy}); end
    tick;
    nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL single_done_len got=%b want=0", done); end
  endtask

  task automatic test_back_to_back;
    int cyc, w, en_cyc, rises, dones;
    int hs_cyc [3];
    logic hs, pen;
    cyc = 0; w = 0; en_cyc = 0; rises = 0; dones = 0; pen = 1'b0;
    hs_cyc[0] = 0; hs_cyc[1] = 0; hs_cyc[2] = 0;
    cfg_in_valid = 1'b1;
    while (cyc < 30) begin
      if (w < 3) begin
        cfg_in_addr = {16'(w), 16'h0010}; cfg_in_data = 32'h1000 + 32'(w); cfg_in_last = (w == 2);
      end
      hs = cfg_in_valid & cfg_in_ready;
      tick; cyc++;
      if (hs) begin hs_cyc[w] = cyc; w++; if (w == 3) cfg_in_valid = 1'b0; end
      if (config_en) en_cyc++;
      if (config_en && !pen) rises++;
      pen = config_en;
      if (done) dones++;
    end
    nvec++; if (w !== 3) begin nerr++; $display("FAIL b2b_words got=%0d want=3", w); end
    nvec++; if (hs_cyc[1] - hs_cyc[0] !== 4) begin nerr++; $display("FAIL b2b_space01 got=%0d want=4", hs_cyc[1] - hs_cyc[0]); end
    nvec++; if (hs_cyc[2] - hs_cyc[1] !== 4) begin nerr++; $display("FAIL b2b_space12 got=%0d want=4", hs_cyc[2] - hs_cyc[1]); end
    nvec++; if (en_cyc !== 6) begin nerr++; $display("FAIL b2b_en_cycles got=%0d want=6", en_cyc); end
    nvec++; if (rises !== 3) begin nerr++; $display("FAIL b2b_windows got=%0d want=3", rises); end
    nvec++; if (dones !== 1) begin nerr++; $display("FAIL b2b_dones got=%0d want=1", dones); end
    nvec++; if (word_count !== 16'd3) begin nerr++; $display("FAIL b2b_wc got=%0d want=3", word_count); end
    nvec++; if (config_addr !== 32'h0002_0010) begin nerr++; $display("FAIL b2b_addr got=%h want=00020010", config_addr); end
  endtask

  task automatic test_gap0;
    int cyc, w, en_cyc, rises, dones;
    int hs_cyc [2];
    logic hs, pen;
    cyc = 0; w = 0; en_cyc = 0; rises = 0; dones = 0; pen = 1'b0;
    hs_cyc[0] = 0; hs_cyc[1] = 0;
    g_valid = 1'b1;
    while (cyc < 20) begin
      if (w < 2) begin g_addr = {16'(w + 7), 16'h0001}; g_data = 32'h2000 + 32'(w); g_last = (w == 1); end
      hs = g_valid & g_ready;
      tick; cyc++;
      if (hs) begin hs_cyc[w] = cyc; w++; if (w == 2) g_valid = 1'b0; end
      if (g_en) en_cyc++;
      if (g_en && !pen) rises++;
      pen = g_en;
      if (g_done) dones++;
    end
    nvec++; if (hs_cyc[1] - hs_cyc[0] !== 3) begin nerr++; $display("FAIL gap0_space got=%0d want=3", hs_cyc[1] - hs_cyc[0]); end
    nvec++; if (en_cyc !== 4) begin nerr++; $display("FAIL gap0_en_cycles got=%0d want=4", en_cyc); end
    nvec++; if (rises !== 2) begin nerr++; $display("FAIL gap0_windows got=%0d want=2", rises); end
    nvec++; if (dones !== 1) begin nerr++; $display("FAIL gap0_dones got=%0d want=1", dones); end
    nvec++; if (g_wc !== 16'd2) begin nerr++; $display("FAIL gap0_wc got=%0d want=2", g_wc); end
  endtask

  task automatic test_abort;
    int dones;
    push(32'h0001_0002, 32'hA5A5_0001, 1'b1);
    nvec++; if (config_en !== 1'b1) begin nerr++; $display("FAIL abort_pre_en got=%b want=1", config_en); end
    nvec++; if (word_count !== 16'd1) begin nerr++; $display("FAIL abort_pre_wc got=%0d want=1", word_count); end
    abort = 1'b1; tick; abort = 1'b0;
    nvec++; if ({config_en, cfg_in_ready, busy} !== 3'b010) begin nerr++; $display("FAIL abort_state got=%b want=010", {config_en, cfg_in_ready, busy}); end
    nvec++; if (word_count !== 16'd1) begin nerr++; $display("FAIL abort_wc got=%0d want=1", word_count); end
    dones = 0;
    repeat (5) begin tick; if (done) dones++; end
    nvec++; if (dones !== 0) begin nerr++; $display("FAIL abort_no_done got=%0d want=0", dones); end
    cfg_in_valid = 1'b1; cfg_in_addr = 32'h0002_0003; cfg_in_data = 32'h1; cfg_in_last = 1'b0;
    abort = 1'b1; tick; abort = 1'b0; cfg_in_valid = 1'b0;
    nvec++; if ({config_en, busy} !== 2'b00) begin nerr++; $display("FAIL abort_prio_state got=%b want=00", {config_en, busy}); end
    nvec++; if (config_addr !== 32'h0001_0002) begin nerr++; $display("FAIL abort_prio_addr got=%h want=00010002", config_addr); end
    nvec++; if (word_count !== 16'd1) begin nerr++; $display("FAIL abort_prio_wc got=%0d want=1", word_count); end
    push(32'h0002_0003, 32'h5A5A_0002, 1'b1);
    nvec++; if (config_en !== 1'b1) begin nerr++; $display("FAIL abort_next_en got=%b want=1", config_en); end
    nvec++; if (config_data !== 32'h5A5A_0002) begin nerr++; $display("FAIL abort_next_data got=%h want=5a5a0002", config_data); end
    nvec++; if (word_count !== 16'd2) begin nerr++; $display("FAIL abort_next_wc got=%0d want=2", word_count); end
    tick; tick; tick;
    nvec++; if (done !== 1'b1) begin nerr++; $display("FAIL abort_next_done got=%b want=1", done); end
  endtask

  task automatic test_reset_mid_hold;
    int dones;
    push(32'h0004_0000, 32'hCAFE_F00D, 1'b0);
    nvec++; if (config_en !== 1'b1) begin nerr++; $display("FAIL rmh_pre_en got=%b want=1", config_en); end
    reset = 1'b0; tick;
    nvec++; if ({config_en, busy, done, cfg_in_ready} !== 4'b0000) begin nerr++; $display("FAIL rmh_ctl got=%b want=0000", {config_en, busy, done, cfg_in_ready}); end
    nvec++; if ({config_addr, config_data} !== 64'h0) begin nerr++; $display("FAIL rmh_bus got=%h want=0", {config_addr, config_data}); end
    nvec++; if ({word_count, err_count} !== 32'h0) begin nerr++; $display("FAIL rmh_cnt got=%h want=0", {word_count, err_count}); end
    reset = 1'b1; #1;
    nvec++; if (cfg_in_ready !== 1'b1) begin nerr++; $display("FAIL rmh_ready got=%b want=1", cfg_in_ready); end
    dones = 0;
    repeat (6) begin tick; if (done) dones++; end
    nvec++; if (dones !== 0) begin nerr++; $display("FAIL rmh_spurious_done got=%0d want=0", dones); end
  endtask

  task automatic test_tile_check;
    int dones;
    dones = 0;
`ifdef CFG_TILE_CHECK_EN
    push(32'h0014_0007, 32'h0000_1111, 1'b0);
    nvec++; if ({config_en, busy, cfg_in_ready} !== 3'b001) begin nerr++; $display("FAIL tile_drop_state got=%b want=001", {config_en, busy, cfg_in_ready}); end
    nvec++; if (err_count !== 16'd1) begin nerr++; $display("FAIL tile_drop_ec got=%0d want=1", err_count); end
    nvec++; if (word_count !== 16'd0) begin nerr++; $display("FAIL tile_drop_wc got=%0d want=0", word_count); end
    nvec++; if (config_addr !== 32'h0) begin nerr++; $display("FAIL tile_drop_bus got=%h want=0", config_addr); end
    push(32'hFFFF_0008, 32'h0000_2222, 1'b0);
    nvec++; if (config_en !== 1'b1) begin nerr++; $display("FAIL tile_bcast_en got=%b want=1", config_en); end
    nvec++; if (config_addr !== 32'hFFFF_0008) begin nerr++; $display("FAIL tile_bcast_addr got=%h want=ffff0008", config_addr); end
    push(32'h0005_0009, 32'h0000_3333, 1'b1);
    repeat (4) begin tick; if (done) dones++; end
    nvec++; if (word_count !== 16'd2) begin nerr++; $display("FAIL tile_wc got=%0d want=2", word_count); end
    nvec++; if (err_count !== 16'd1) begin nerr++; $display("FAIL tile_ec got=%0d want=1", err_count); end
    nvec++; if (dones !== 1) begin nerr++; $display("FAIL tile_dones got=%0d want=1", dones); end
    nvec++; if (config_addr !== 32'h0005_0009) begin nerr++; $display("FAIL tile_addr got=%h want=00050009", config_addr); end
`else
    push(32'h0014_0007, 32'h0000_1111, 1'b1);
    nvec++; if (config_en !== 1'b1) begin nerr++; $display("FAIL nochk_en got=%b want=1", config_en); end
    nvec++; if (config_addr !== 32'h0014_0007) begin nerr++; $display("FAIL nochk_addr got=%h want=00140007", config_addr); end
    nvec++; if (word_count !== 16'd1) begin nerr++; $display("FAIL nochk_wc got=%0d want=1", word_count); end
    repeat (4) begin tick; if (done) dones++; end
    nvec++; if (err_count !== 16'd0) begin nerr++; $display("FAIL nochk_ec got=%0d want=0", err_count); end
    nvec++; if (dones !== 1) begin nerr++; $display("FAIL nochk_dones got=%0d want=1", dones); end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_gap0;
    test_abort;
    test_reset_mid_hold;
    test_tile_check;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/config_sequencer.md
Name: config_sequencer

Overview:
- Sequences the fabric configuration bus (config_addr / config_data) that feeds every PE tile's address matcher.
- Accepts a stream of (addr, data) configuration words from the host/loader over a valid/ready handshake.
- Drives each word onto the broadcast bus with a qualifying config_en strobe for a fixed hold window, then a fixed idle gap, so long broadcast wires settle.
- Reports busy/done status and word/error counts.

Parameters:
- HOLD_CYCLES, 2, cycles config_en stays high per word (legal range >=1).
- GAP_CYCLES, 1, idle cycles after each hold window before the next word is accepted (legal range >=0).
- NUM_TILES, 16, number of valid tile ids, 0..NUM_TILES-1; tile id 16'hFFFF means broadcast.
- CNT_W, 16, width of word_count and err_count.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous active-low reset; sampled on the rising edge of clk.
- abort  input  1  synchronous abort of the current sequence.
- cfg_in_valid  input  1  host word valid.
- cfg_in_ready  output  1  sequencer can accept a word.
- cfg_in_addr  input  32  [31:16] = tile_id, [15:0] = config_id.
- cfg_in_data  input  32  configuration payload.
- cfg_in_last  input  1  marks the final word of a sequence.
- config_addr  output  32  broadcast address to the tiles.
- config_data  output  32  broadcast data to the tiles.
- config_en  output  1  bus qualifier; tiles latch only while it is high.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a last word completes.
- word_count  output  CNT_W  words issued since the sequence start.
- err_count  output  CNT_W  words dropped by the tile check.

Behaviour:
- Reset (reset==0 at an edge): state IDLE; config_en=0, config_addr=0, config_data=0, done=0, busy=0, word_count=0, err_count=0. cfg_in_ready=0 while reset is asserted and 1 in the first cycle after release.
- States: IDLE, HOLD, GAP.
- cfg_in_ready = 1 only in IDLE. Nothing is registered without a handshake (valid & ready at an edge).
- IDLE -> HOLD on handshake at edge N:
  - addr, data and last are captured.
  - config_addr/config_data take the captured values from cycle N+1.
  - config_en = 1 for cycles N+1 .. N+HOLD_CYCLES.
  - word_count increments at the edge entering HOLD.
- HOLD -> GAP after HOLD_CYCLES cycles. If GAP_CYCLES==0, HOLD -> IDLE directly.
- GAP: config_en=0; config_addr/config_data keep their last values. After GAP_CYCLES cycles -> IDLE.
- Throughput: one word per 1+HOLD_CYCLES+GAP_CYCLES cycles.
- done pulses for exactly one cycle, in the first cycle back in IDLE, if the completed word had last=1.
- word_count and err_count clear at the first handshake after a done pulse; that first word counts as 1. Counters wrap modulo 2^CNT_W.
- cfg_in_valid may drop without a handshake; no state change results.
- abort==1 at an edge, any state:
  - state goes to IDLE; config_en=0 from the next cycle.
  - no done pulse; counters are held; the captured word is discarded.
  - abort has priority over a simultaneous handshake: the word is not accepted.
- Reset mid-HOLD: config_en falls at the reset edge; all outputs return to their reset values.
- config_addr/config_data change only at a handshake edge, or at reset.

Optional Feature:
- Macro: CFG_TILE_CHECK_EN.
- Defined:
  - An accepted word with tile_id >= NUM_TILES and != 16'hFFFF is dropped: no HOLD/GAP, config_en stays 0, the bus is not updated.
  - err_count increments and state stays IDLE, so ready remains 1.
  - If the dropped word had last=1, done pulses in the next cycle.
  - word_count does not increment.
- Not defined: every word is issued; err_count is constant 0.

Test Plan:
- HOLD=2, GAP=1: push addr 32'h0003_0001, data 32'hDEADBEEF, last=1 at edge N -> config_en high in cycles N+1 and N+2, bus holds those values; ready low N+1..N+3; done pulse at N+4; word_count=1.
- Back-to-back: host holds valid for 3 words, the last with last=1 -> handshakes exactly 4 cycles apart, 3 separate config_en windows of 2 cycles each, one done pulse, word_count=3.
- GAP_CYCLES=0 build: 2 words -> handshakes 3 cycles apart, no idle cycle between windows.
- Assert abort in the first HOLD cycle -> config_en low from the next cycle, no done pulse, ready=1, word_count unchanged. A subsequent word issues normally.
- With CFG_TILE_CHECK_EN and NUM_TILES=16: words with tile_id 20 (last=0), 16'hFFFF, then 5 (last=1) -> tile 20 dropped with err_count=1; broadcast and tile 5 issued with word_count=2; done pulses once.
- Drive reset low during HOLD -> next cycle config_en=0, bus=0, counters=0, busy=0. After release, ready=1 and no spurious done pulse.
